// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and helpers for the DMA channel arbiter slice.
package dma_pkg;

  // Largest supported channel count; also the width of the priority-encoder helper.
  localparam int NUM_CH_MAX = 16;
  localparam int IDX_W      = $clog2(NUM_CH_MAX);

  // One-hot arbiter states.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } arb_state_e;

  // Index of the lowest set bit; 0 when the vector is empty (caller qualifies with a found flag).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH_MAX-1:0] vec);
    lowest_set = '0;
    for (int i = NUM_CH_MAX - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Pin-level bundle between the bus interface / timing & control and the arbiter.
// The master side drives requests and handshake inputs; the slave side is the arbiter.
interface dma_channel_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic [NUM_CH-1:0] maskReg;
  logic [NUM_CH-1:0] softReq;
  logic              priorityType;
  logic              dreqSense;
  logic              dackSense;
  logic              arbEnable;
  logic              xferDone;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic              grantValid;
  logic [CH_W-1:0]   grantCh;

  modport master (
    output DREQ, HLDA, maskReg, softReq, priorityType, dreqSense, dackSense, arbEnable, xferDone,
    input  HRQ, DACK, grantValid, grantCh
  );

  modport slave (
    input  DREQ, HLDA, maskReg, softReq, priorityType, dreqSense, dackSense, arbEnable, xferDone,
    output HRQ, DACK, grantValid, grantCh
  );

endinterface

// File: rtl/dma_channel_arbiter_rr_pick.sv
// Combinational winner selection: fixed (ch0 highest) or rotating from a pointer.
// The request vector is rotated right by the start index via a double-width shift,
// the lowest set bit is found, and the offset is mapped back to a channel index.
module dma_rr_pick
  import dma_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eff,
  input  logic [CH_W-1:0]   pointer,
  input  logic              priority_type,
  output logic              found,
  output logic [CH_W-1:0]   winner
);

  logic [CH_W-1:0]   start;
  logic [NUM_CH-1:0] rotated;
  logic [IDX_W-1:0]  offset;
  logic [CH_W:0]     sum;

  // Rotate, encode, and un-rotate the winning index.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    start   = priority_type ? pointer : '0;
    rotated = NUM_CH'({eff, eff} >> start);
    offset  = lowest_set(NUM_CH_MAX'(rotated));
    sum     = (CH_W+1)'(offset) + (CH_W+1)'(start);
    found   = |eff;
    winner  = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH)) : CH_W'(sum);
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA request arbiter and HRQ/HLDA hold handshaker.
// Qualifies raw requests, picks a winner, holds the bus for it and drives its DACK
// until the timing & control block reports completion or the CPU revokes HLDA.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input logic                  CLK,
  input logic                  RESET_N,
  dma_channel_arbiter_if.slave bus
);

  arb_state_e        state;
  logic              hrq_q;
  logic              grant_valid_q;
  logic [CH_W-1:0]   grant_ch_q;
  logic [NUM_CH-1:0] grant_oh_q;
  logic [CH_W-1:0]   ptr_q;

  logic [NUM_CH-1:0] eff;
  logic              found;
  logic              any_req;
  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   next_ptr;

  // Request qualification: sense, mask, then software requests bypass the mask.
  assign eff     = ((bus.DREQ ^ {NUM_CH{bus.dreqSense}}) & ~bus.maskReg) | bus.softReq;
  assign any_req = found & bus.arbEnable;

  // Served channel becomes lowest priority on the next rotating search.
  assign next_ptr = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + CH_W'(1);

  dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .eff           (eff),
    .pointer       (ptr_q),
    .priority_type (bus.priorityType),
    .found         (found),
    .winner        (winner)
  );

  // Hold-handshake FSM with registered HRQ, grant and pointer state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      hrq_q         <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= '0;
      grant_oh_q    <= '0;
      ptr_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state <= REQ;
            hrq_q <= 1'b1;
          end
        end
        REQ: begin
          if (!any_req) begin
            state <= IDLE;
            hrq_q <= 1'b0;
          end else if (bus.HLDA) begin
            state      <= GRANT;
            grant_ch_q <= winner;
          end
        end
        GRANT: begin
          if (bus.xferDone || !bus.HLDA) begin
            state         <= RELEASE;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_oh_q    <= '0;
            // A revoke alone is an abort and leaves the pointer where it was.
            if (bus.xferDone && bus.priorityType) ptr_q <= next_ptr;
          end else begin
            grant_valid_q <= 1'b1;
            grant_oh_q    <= NUM_CH'(1) << grant_ch_q;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          hrq_q         <= 1'b0;
          grant_valid_q <= 1'b0;
          grant_oh_q    <= '0;
        end
      endcase
    end
  end

  assign bus.HRQ        = hrq_q;
  assign bus.grantValid = grant_valid_q;
  assign bus.grantCh    = grant_ch_q;
  assign bus.DACK       = bus.dackSense ? grant_oh_q : ~grant_oh_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed, scoreboard-checked bench for dma_channel_arbiter with NUM_CH = 4.
module tb_dma_channel_arbiter;
  import dma_pkg::*;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_ptr  = 0;
  int last_grant = 0;

  arb_state_e prev_state = IDLE;
  logic       hlda_prev  = 1'b0;

  dma_channel_arbiter_if #(.NUM_CH(4)) bus ();

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counted, asserted, reported.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] act_dack();
    return bus.dackSense ? bus.DACK : ~bus.DACK;
  endfunction

  // Reference winner: linear search from the start index, wrapping.
  function automatic int model_pick(input logic [3:0] e, input int ptr, input bit rot);
    int s;
    int c;
    s = rot ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      c = (s + k) % 4;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  // Push the expected winner for the request pattern currently being driven.
  task automatic start_service();
    logic [3:0] e;
    e = ((bus.DREQ ^ {4{bus.dreqSense}}) & ~bus.maskReg) | bus.softReq;
    exp_q.push_back(model_pick(e, exp_ptr, bus.priorityType));
  endtask

  // Wait (bounded) for a grant, then compare against the scoreboard.
  task automatic wait_grant(input int max_cycles);
    int n;
    int e;
    n = 0;
    while (bus.grantValid !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check("grant_arrives", bus.grantValid, 1);
    check("scoreboard_has_entry", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_grant = e;
      check("grant_ch", bus.grantCh, e);
      check("grant_dack", act_dack(), 4'b0001 << e);
      check("grant_hrq", bus.HRQ, 1);
    end
  endtask

  // Pulse xferDone, expect the one-cycle RELEASE state.
  task automatic complete(input logic [3:0] next_dreq);
    bus.xferDone = 1'b1;
    bus.DREQ     = next_dreq;
    step();
    bus.xferDone = 1'b0;
    if (bus.priorityType) exp_ptr = (last_grant + 1) % 4;
    check("release_grant_valid", bus.grantValid, 0);
    check("release_hrq", bus.HRQ, 0);
    check("release_dack", act_dack(), 0);
  endtask

  // Cycle-by-cycle protocol invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      check("dack_onehot0", $onehot0(act_dack()), 1);
      check("dack_only_in_grant", (act_dack() == 0) || (bus.grantValid && dut.state == GRANT), 1);
      check("grant_valid_implies_hrq", !bus.grantValid || bus.HRQ, 1);
      if (prev_state == REQ && dut.state == GRANT) check("req_to_grant_needs_hlda", hlda_prev, 1);
    end
    prev_state = dut.state;
    hlda_prev  = bus.HLDA;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.DREQ         = 4'b0000;
    bus.HLDA         = 1'b0;
    bus.maskReg      = 4'b0000;
    bus.softReq      = 4'b0000;
    bus.priorityType = 1'b0;
    bus.dreqSense    = 1'b0;
    bus.dackSense    = 1'b0;
    bus.arbEnable    = 1'b1;
    bus.xferDone     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    check("reset_hrq", bus.HRQ, 0);
    check("reset_grant_valid", bus.grantValid, 0);
    check("reset_grant_ch", bus.grantCh, 0);
    check("reset_dack", bus.DACK, 4'b1111);

    // 1. Fixed priority, HLDA tied high: HRQ at t+1, DACK at t+3.
    bus.HLDA = 1'b1;
    bus.DREQ = 4'b0011;
    start_service();
    step();
    check("t1_hrq_t1", bus.HRQ, 1);
    check("t1_dack_t1", bus.DACK, 4'b1111);
    step();
    check("t1_grant_valid_t2", bus.grantValid, 0);
    check("t1_dack_t2", bus.DACK, 4'b1111);
    step();
    check("t1_dack_t3", bus.DACK, 4'b1110);
    wait_grant(0);
    complete(4'b0000);
    check("t1_dack_after_done", bus.DACK, 4'b1111);
    step();

    // 2. Rotating priority, all channels requesting: 0,1,2,3,0.
    bus.priorityType = 1'b1;
    bus.DREQ         = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      start_service();
      wait_grant(10);
      complete((i == 4) ? 4'b0000 : 4'b1111);
    end
    step();

    // 5. Abort by HLDA drop in GRANT ch2; pointer must not rotate.
    bus.DREQ = 4'b0100;
    start_service();
    wait_grant(10);
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b0000;
    step();
    check("t5_abort_grant_valid", bus.grantValid, 0);
    check("t5_abort_hrq", bus.HRQ, 0);
    check("t5_abort_dack", bus.DACK, 4'b1111);
    step();
    bus.HLDA = 1'b1;
    bus.DREQ = 4'b1111;
    start_service();
    wait_grant(10);
    complete(4'b0000);
    step();

    // 3. Masked request ignored; soft request overrides the mask.
    bus.priorityType = 1'b0;
    bus.maskReg      = 4'b0001;
    bus.DREQ         = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_masked_hrq", bus.HRQ, 0);
    end
    bus.softReq = 4'b0001;
    start_service();
    wait_grant(10);
    bus.softReq = 4'b0000;
    bus.maskReg = 4'b0000;
    step();
    check("t3_grant_held", bus.grantCh, 0);
    complete(4'b0000);
    step();

    // 4. One-cycle request pulse with HLDA low: HRQ high for exactly one cycle.
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b0100;
    step();
    check("t4_hrq_up", bus.HRQ, 1);
    bus.DREQ = 4'b0000;
    step();
    check("t4_hrq_down", bus.HRQ, 0);
    step();
    check("t4_hrq_idle", bus.HRQ, 0);
    check("t4_no_dack", bus.DACK, 4'b1111);
    check("t4_no_grant", bus.grantValid, 0);

    // 6. Asynchronous reset mid-GRANT.
    bus.HLDA = 1'b1;
    bus.DREQ = 4'b0010;
    start_service();
    wait_grant(10);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_reset_hrq", bus.HRQ, 0);
    check("t6_reset_dack", bus.DACK, 4'b1111);
    check("t6_reset_grant_valid", bus.grantValid, 0);
    check("t6_reset_grant_ch", bus.grantCh, 0);
    bus.dackSense = 1'b1;
    #1;
    check("t6_reset_dack_high_sense", bus.DACK, 4'b0000);
    bus.DREQ = 4'b0000;
    rst_n    = 1'b1;
    exp_ptr  = 0;
    step();

    // Inverted senses: active-low DREQ, active-high DACK.
    bus.dreqSense = 1'b1;
    bus.DREQ      = 4'b1011;
    start_service();
    wait_grant(10);
    check("inv_dack_raw", bus.DACK, 4'b0100);
    complete(4'b1111);
    check("inv_dack_released", bus.DACK, 4'b0000);
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
